// File: rtl/combo_tracker.sv
// combo_tracker: rhythm-game combo/multiplier/score tracker; FULL_COMBO_BONUS_EN adds a +100 full-combo bonus at song end
module combo_tracker (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        song_start,
  input  logic        song_end,
  input  logic        hit_valid,
  input  logic [1:0]  hit_grade,
  output logic [7:0]  combo_count,
  output logic [7:0]  max_combo,
  output logic [2:0]  mult,
  output logic [15:0] total_score,
  output logic        score_valid,
  output logic        playing,
  output logic        full_combo
);
  typedef enum logic [1:0] {IDLE, PLAYING, FINISHED} state_t;
  state_t      state, state_nx;
  logic        miss_flag, accept, s2_valid, bonus_add;
  logic [3:0]  s2_pts;
  logic [7:0]  combo_nx;
  logic [2:0]  mult_nx;
  logic [16:0] sum;
  function automatic logic [2:0] mult_of(input logic [7:0] c);
    return c <= 8'd5 ? 3'd1 : c <= 8'd13 ? 3'd2 : c <= 8'd24 ? 3'd3 : c <= 8'd38 ? 3'd4 : 3'd5;
  endfunction
  // state register
  always_ff @(posedge Clk) state <= !Reset ? IDLE : state_nx;
  // next state: a new song may start from any state and wins over song_end
  always_comb state_nx = song_start ? PLAYING : (state == PLAYING && song_end) ? FINISHED : state;
  // state-derived outputs and the multiplier of the registered combo
  always_comb begin
    playing    = state == PLAYING;
    full_combo = state == FINISHED && !miss_flag && max_combo != 8'd0;
    mult       = mult_of(combo_count);
  end
  // stage-1 next values; the points use the multiplier of the post-hit combo
  always_comb begin
    accept   = playing && hit_valid && !song_start;
    combo_nx = hit_grade == 2'd0 ? 8'd0 : combo_count == 8'hFF ? 8'hFF : combo_count + 8'd1;
    mult_nx  = mult_of(combo_nx);
  end
  // stage 1: combo, max combo and miss flag, plus the points handed to stage 2
  always_ff @(posedge Clk) begin
    if (!Reset || song_start) begin
      combo_count <= '0;
      max_combo   <= '0;
      miss_flag   <= 1'b0;
      s2_valid    <= 1'b0;
      s2_pts      <= '0;
    end else begin
      s2_valid <= accept;
      s2_pts   <= 4'({2'b00, hit_grade} * {1'b0, mult_nx});
      if (accept) begin
        combo_count <= combo_nx;
        miss_flag   <= miss_flag | (hit_grade == 2'd0);
        max_combo   <= combo_nx > max_combo ? combo_nx : max_combo;
      end
    end
  end
`ifdef FULL_COMBO_BONUS_EN
  logic bonus_end, bonus_due;
  // bonus is qualified one cycle after the end so a hit arriving with song_end counts toward the miss flag
  always_ff @(posedge Clk) begin
    if (!Reset || song_start) begin
      bonus_end <= 1'b0;
      bonus_due <= 1'b0;
    end else begin
      bonus_end <= playing && song_end;
      bonus_due <= bonus_end && !miss_flag && max_combo != 8'd0;
    end
  end
  assign bonus_add = bonus_due;
`else
  assign bonus_add = 1'b0;
`endif
  // saturating accumulation of stage-2 points and any bonus
  always_comb sum = {1'b0, total_score} + (s2_valid ? {13'd0, s2_pts} : 17'd0) + (bonus_add ? 17'd100 : 17'd0);
  // stage 2: score register and its update strobe; a new song discards the in-flight update
  always_ff @(posedge Clk) begin
    if (!Reset || song_start) begin
      total_score <= '0;
      score_valid <= 1'b0;
    end else begin
      total_score <= sum[16] ? 16'hFFFF : sum[15:0];
      score_valid <= s2_valid | bonus_add;
    end
  end
endmodule

// File: tb/tb_combo_tracker.sv
// tb_combo_tracker: directed scoreboard bench for combo_tracker
module tb_combo_tracker;
  logic        Clk = 1'b0, Reset = 1'b0, song_start = 1'b0, song_end = 1'b0, hit_valid = 1'b0;
  logic [1:0]  hit_grade = 2'd0;
  logic [7:0]  combo_count, max_combo;
  logic [2:0]  mult;
  logic [15:0] total_score;
  logic        score_valid, playing, full_combo;
`ifdef FULL_COMBO_BONUS_EN
  localparam int BONUS = 100;
`else
  localparam int BONUS = 0;
`endif
  int vectors = 0, miscompares = 0;
  int m_combo = 0, m_max = 0, m_score = 0;
  bit m_miss = 1'b0, m_play = 1'b0;
  logic [15:0] sb[$];

  combo_tracker dut (
    .Clk(Clk), .Reset(Reset), .song_start(song_start), .song_end(song_end),
    .hit_valid(hit_valid), .hit_grade(hit_grade), .combo_count(combo_count),
    .max_combo(max_combo), .mult(mult), .total_score(total_score),
    .score_valid(score_valid), .playing(playing), .full_combo(full_combo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int tmult(input int c);
    if (c < 6) return 1;
    if (c < 14) return 2;
    if (c < 25) return 3;
    if (c < 39) return 4;
    return 5;
  endfunction

  task automatic push_score(input int add);
    m_score = m_score + add > 65535 ? 65535 : m_score + add;
    sb.push_back(16'(m_score));
  endtask

  task automatic model_hit(input int g);
    if (!m_play) return;
    m_combo = g == 0 ? 0 : (m_combo < 255 ? m_combo + 1 : 255);
    if (g == 0) m_miss = 1'b1;
    if (m_combo > m_max) m_max = m_combo;
    push_score(g * tmult(m_combo));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic hits(input int n, input int g);
    hit_valid = 1'b1;
    hit_grade = 2'(g);
    repeat (n) begin
      @(posedge Clk);
      #1;
      model_hit(g);
    end
    hit_valid = 1'b0;
  endtask

  task automatic start(input bit with_hit);
    song_start = 1'b1;
    hit_valid  = with_hit;
    hit_grade  = 2'd3;
    idle(1);
    song_start = 1'b0;
    hit_valid  = 1'b0;
    m_combo = 0; m_max = 0; m_score = 0; m_miss = 1'b0; m_play = 1'b1;
  endtask

  task automatic end_song(input bit with_hit, input int g);
    song_end  = 1'b1;
    hit_valid = with_hit;
    hit_grade = 2'(g);
    idle(1);
    song_end  = 1'b0;
    hit_valid = 1'b0;
    if (with_hit) model_hit(g);
    if (BONUS != 0 && m_play && !m_miss && m_max != 0) push_score(BONUS);
    m_play = 1'b0;
  endtask

  // monitor: every score_valid pulse must match the next queued expectation
  always @(negedge Clk) begin
    if (score_valid) begin
      if (sb.size() == 0) check("unexpected_score_valid", int'(total_score), -1);
      else check("score", int'(total_score), int'(sb.pop_front()));
    end
  end

  initial begin
    idle(2);
    check("rst_combo", combo_count, 0);
    check("rst_max", max_combo, 0);
    check("rst_mult", mult, 1);
    check("rst_score", total_score, 0);
    check("rst_valid", score_valid, 0);
    check("rst_playing", playing, 0);
    check("rst_full", full_combo, 0);
    Reset = 1'b1;
    idle(1);
    hits(1, 3);
    idle(3);
    check("idle_hit_score", total_score, 0);
    check("idle_hit_combo", combo_count, 0);

    start(1'b0);
    check("playing", playing, 1);
    hits(6, 3);
    idle(1);
    check("six_combo", combo_count, 6);
    check("six_mult", mult, 2);
    idle(1);
    check("six_score", total_score, 21);

    idle(3);
    start(1'b0);
    hits(14, 1);
    hits(1, 0);
    idle(2);
    check("miss_combo", combo_count, 0);
    check("miss_max", max_combo, 14);
    check("miss_mult", mult, 1);
    check("miss_score", total_score, 24);

    idle(3);
    start(1'b0);
    hits(5, 2);
    Reset = 1'b0;
    idle(1);
    sb.delete();
    m_play = 1'b0;
    Reset = 1'b1;
    check("midrst_combo", combo_count, 0);
    check("midrst_score", total_score, 0);
    check("midrst_playing", playing, 0);
    check("midrst_mult", mult, 1);
    idle(3);

    start(1'b0);
    hits(2, 3);
    idle(3);
    start(1'b1);
    idle(2);
    check("start_hit_combo", combo_count, 0);
    check("start_hit_score", total_score, 0);
    hits(3, 1);
    end_song(1'b1, 2);
    check("end_hit_playing", playing, 0);
    idle(1);
    check("end_hit_combo", combo_count, 4);
    idle(2);
    check("end_hit_score", total_score, 5 + BONUS);
    check("end_hit_full", full_combo, 1);

    idle(3);
    start(1'b0);
    hits(10, 1);
    end_song(1'b0, 0);
    idle(4);
    check("fc_full", full_combo, 1);
    check("fc_max", max_combo, 10);
    check("fc_score", total_score, 15 + BONUS);

    idle(3);
    start(1'b0);
    hits(3, 0);
    end_song(1'b0, 0);
    idle(4);
    check("nofc_full", full_combo, 0);

    idle(3);
    start(1'b0);
    hits(300, 3);
    idle(1);
    check("sat_combo_300", combo_count, 255);
    hits(4100, 3);
    idle(2);
    check("sat_combo", combo_count, 255);
    check("sat_max", max_combo, 255);
    check("sat_mult", mult, 5);
    check("sat_score", total_score, 65535);

    idle(3);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
